// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: latency constants, stall causes and
// the pipeline enable/flush bundle produced by the priority mux.
package hazard_pkg;

    localparam int unsigned HZ_LAT_W = 3;

    typedef logic [HZ_LAT_W-1:0] lat_t;

    localparam lat_t LAT_ALU  = lat_t'(0);
    localparam lat_t LAT_LOAD = lat_t'(1);

    typedef enum logic [1:0] {
        STALL_NONE,
        STALL_MEM_WAIT,
        STALL_REDIRECT,
        STALL_DATA
    } stall_cause_e;

    typedef struct packed {
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic fl_if_id;
        logic fl_id_ex;
        logic fl_mem_wb;
    } pipe_ctl_t;

    function automatic pipe_ctl_t cause_to_ctl(input stall_cause_e cause);
        pipe_ctl_t ctl;
        ctl = '{if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                fl_if_id: 1'b0, fl_id_ex: 1'b0, fl_mem_wb: 1'b0};
        case (cause)
            STALL_MEM_WAIT: begin
                // Only MEM/WB advances, and it takes a bubble while the access is pending.
                ctl.if_id_en  = 1'b0;
                ctl.id_ex_en  = 1'b0;
                ctl.ex_mem_en = 1'b0;
                ctl.fl_mem_wb = 1'b1;
            end
            STALL_REDIRECT: begin
                ctl.fl_if_id = 1'b1;
                ctl.fl_id_ex = 1'b1;
            end
            STALL_DATA: begin
                ctl.if_id_en = 1'b0;
                ctl.fl_id_ex = 1'b1;
            end
            default: ;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: a nonzero count means the register's
// result is not yet forwardable. Entry 0 is hardwired to zero.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG    = 32,
    parameter int unsigned RIDX_W  = $clog2(NREG),
    parameter int unsigned LAT_W   = 3,
    parameter int unsigned MAX_LAT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_issue,
    input  logic [RIDX_W-1:0] i_issue_rd,
    input  logic [LAT_W-1:0]  i_issue_lat,
    input  logic [RIDX_W-1:0] i_rs1,
    input  logic [RIDX_W-1:0] i_rs2,
    output logic              o_busy1,
    output logic              o_busy2
);

    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] r_sb_cnt [1:NREG-1];
    logic [LAT_W-1:0] w_lat_sat;

    assign w_lat_sat = (i_issue_lat > MAX_LAT_V) ? MAX_LAT_V : i_issue_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                r_sb_cnt[i] <= '0;
            end
        end else if (!i_hold) begin
            // The issue write takes precedence over the decrement of the same entry.
            for (int unsigned i = 1; i < NREG; i++) begin
                if (i_issue && (i_issue_rd == RIDX_W'(i))) begin
                    r_sb_cnt[i] <= w_lat_sat;
                end else if (r_sb_cnt[i] != '0) begin
                    r_sb_cnt[i] <= r_sb_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_busy1 = 1'b0;
        o_busy2 = 1'b0;
        if (i_rs1 != '0) begin
            o_busy1 = (r_sb_cnt[i_rs1] != '0);
        end
        if (i_rs2 != '0) begin
            o_busy2 = (r_sb_cnt[i_rs2] != '0);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritises memory wait, branch redirect and
// data hazards into per-register enables/flushes, and counts stall cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NREG     = 32,
    parameter int unsigned RIDX_W   = $clog2(NREG),
    parameter int unsigned LAT_W    = 3,
    parameter int unsigned MAX_LAT  = 7,
    parameter int unsigned PCNT_W   = 32,
    parameter logic [1:0]  BUS_NONE = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] ID_rs1,
    input  logic [RIDX_W-1:0] ID_rs2,
    input  logic              ID_rs1_used,
    input  logic              ID_rs2_used,
    input  logic [RIDX_W-1:0] ID_rd,
    input  logic              ID_vld,
    input  logic [LAT_W-1:0]  ID_lat,
    input  logic [1:0]        EX_MEM_mem_cmd,
    input  logic              DM_rdy,
    input  logic              EX_redirect,
    output logic              ST_if_id_en,
    output logic              ST_id_ex_en,
    output logic              ST_ex_mem_en,
    output logic              ST_mem_wb_en,
    output logic              FL_if_id,
    output logic              FL_id_ex,
    output logic              FL_mem_wb,
    output logic [PCNT_W-1:0] PC_data_stalls,
    output logic [PCNT_W-1:0] PC_mem_stalls
);

    logic         w_mem_wait;
    logic         w_busy1;
    logic         w_busy2;
    logic         w_hazard;
    logic         w_issue;
    stall_cause_e w_cause;
    pipe_ctl_t    w_ctl;

    logic [PCNT_W-1:0] r_data_stalls;
    logic [PCNT_W-1:0] r_mem_stalls;

    assign w_mem_wait = (EX_MEM_mem_cmd != BUS_NONE) && !DM_rdy;
    assign w_hazard   = ID_vld && ((ID_rs1_used && w_busy1) || (ID_rs2_used && w_busy2));
    // A redirect squashes the ID instruction, so it must never reserve its rd.
    assign w_issue    = ID_vld && !w_hazard && !EX_redirect && (ID_rd != '0);

    hazard_scoreboard #(
        .NREG    (NREG),
        .RIDX_W  (RIDX_W),
        .LAT_W   (LAT_W),
        .MAX_LAT (MAX_LAT)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_hold      (w_mem_wait),
        .i_issue     (w_issue),
        .i_issue_rd  (ID_rd),
        .i_issue_lat (ID_lat),
        .i_rs1       (ID_rs1),
        .i_rs2       (ID_rs2),
        .o_busy1     (w_busy1),
        .o_busy2     (w_busy2)
    );

    always_comb begin
        w_cause = STALL_NONE;
        if (w_mem_wait) begin
            w_cause = STALL_MEM_WAIT;
        end else if (EX_redirect) begin
            w_cause = STALL_REDIRECT;
        end else if (w_hazard) begin
            w_cause = STALL_DATA;
        end
    end

    assign w_ctl = cause_to_ctl(w_cause);

    assign ST_if_id_en  = w_ctl.if_id_en;
    assign ST_id_ex_en  = w_ctl.id_ex_en;
    assign ST_ex_mem_en = w_ctl.ex_mem_en;
    assign ST_mem_wb_en = w_ctl.mem_wb_en;
    assign FL_if_id     = w_ctl.fl_if_id;
    assign FL_id_ex     = w_ctl.fl_id_ex;
    assign FL_mem_wb    = w_ctl.fl_mem_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_stalls <= '0;
            r_mem_stalls  <= '0;
        end else begin
            if (w_cause == STALL_DATA) begin
                r_data_stalls <= r_data_stalls + 1'b1;
            end
            if (w_cause == STALL_MEM_WAIT) begin
                r_mem_stalls <= r_mem_stalls + 1'b1;
            end
        end
    end

    assign PC_data_stalls = r_data_stalls;
    assign PC_mem_stalls  = r_mem_stalls;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a per-register
// countdown model of the stall rules.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, vld;
    logic [2:0]  lat;
    logic [1:0]  cmd;
    logic        rdy, redir;
    logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        fl_if_id, fl_id_ex, fl_mem_wb;
    logic [31:0] pc_ds, pc_ms;

    int          m_cnt [32];
    logic [31:0] m_ds, m_ms;
    logic [6:0]  last_obs;
    int          total = 0;
    int          bad   = 0;

    hazard_ctrl #(
        .NREG    (32),
        .RIDX_W  (5),
        .LAT_W   (3),
        .MAX_LAT (7),
        .PCNT_W  (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_rs1         (rs1),
        .ID_rs2         (rs2),
        .ID_rs1_used    (u1),
        .ID_rs2_used    (u2),
        .ID_rd          (rd),
        .ID_vld         (vld),
        .ID_lat         (lat),
        .EX_MEM_mem_cmd (cmd),
        .DM_rdy         (rdy),
        .EX_redirect    (redir),
        .ST_if_id_en    (if_id_en),
        .ST_id_ex_en    (id_ex_en),
        .ST_ex_mem_en   (ex_mem_en),
        .ST_mem_wb_en   (mem_wb_en),
        .FL_if_id       (fl_if_id),
        .FL_id_ex       (fl_id_ex),
        .FL_mem_wb      (fl_mem_wb),
        .PC_data_stalls (pc_ds),
        .PC_mem_stalls  (pc_ms)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] a, input logic ua,
                          input logic [4:0] b, input logic ub,
                          input logic [4:0] d, input logic [2:0] l);
        vld = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub; rd = d; lat = l;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_ds = '0;
        m_ms = '0;
    endtask

    // One clock: check enables/flushes mid-cycle, advance the model, check counters.
    task automatic step(input string tag);
        bit         mw, hz;
        logic [6:0] exp;
        @(negedge clk);
        mw = (cmd != 2'b00) && !rdy;
        hz = vld && ((u1 && rs1 != 0 && m_cnt[rs1] > 0) || (u2 && rs2 != 0 && m_cnt[rs2] > 0));
        if (mw)         exp = 7'b0001001;
        else if (redir) exp = 7'b1111110;
        else if (hz)    exp = 7'b0111010;
        else            exp = 7'b1111000;
        last_obs = {if_id_en, id_ex_en, ex_mem_en, mem_wb_en, fl_if_id, fl_id_ex, fl_mem_wb};
        chk7({tag, "_ctl"}, last_obs, exp);
        @(posedge clk);
        if (!mw) begin
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) m_cnt[r]--;
            if (vld && !hz && !redir && rd != 0) m_cnt[rd] = (lat > 7) ? 7 : int'(lat);
        end
        if (hz && !mw && !redir) m_ds++;
        if (mw) m_ms++;
        #1;
        chk32({tag, "_pcds"}, pc_ds, m_ds);
        chk32({tag, "_pcms"}, pc_ms, m_ms);
    endtask

    initial begin
        rst = 1'b0; cmd = 2'b00; rdy = 1'b1; redir = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, LAT_ALU);
        model_clear();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk32("reset_pcds", pc_ds, 32'd0);
        chk32("reset_pcms", pc_ms, 32'd0);
        #1 rst = 1'b0;

        // Load-use: exactly one bubble.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, LAT_LOAD);
        step("ld_r5");
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, LAT_ALU);
        step("add_stall");
        chk7("loaduse_bubble", last_obs, 7'b0111010);
        step("add_issue");
        chk7("loaduse_issue", last_obs, 7'b1111000);
        chk32("loaduse_pcds", pc_ds, 32'd1);

        // Three-cycle producer.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 3'd3);
        step("mul_r7");
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd12, LAT_ALU);
        for (int k = 0; k < 3; k++) begin
            step("dep_r7");
            chk7("lat3_stall", last_obs, 7'b0111010);
        end
        step("dep_r7_go");
        chk7("lat3_issue", last_obs, 7'b1111000);
        chk32("lat3_pcds", pc_ds, 32'd4);

        // Memory wait freezes the scoreboard.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 3'd2);
        step("op_r8");
        set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd14, LAT_ALU);
        cmd = 2'b01; rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step("memwait");
            chk7("memwait_ctl_const", last_obs, 7'b0001001);
        end
        chk32("memwait_pcms", pc_ms, 32'd4);
        cmd = 2'b00; rdy = 1'b1;
        step("post_wait1");
        step("post_wait2");
        step("post_wait3");
        chk7("frozen_sb_issue", last_obs, 7'b1111000);
        chk32("frozen_sb_pcds", pc_ds, 32'd6);

        // Redirect beats a data hazard and squashes ID.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 3'd2);
        step("op_r9");
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 3'd3);
        redir = 1'b1;
        step("redir_hz");
        chk7("redir_ctl_const", last_obs, 7'b1111110);
        redir = 1'b0;
        set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd13, LAT_ALU);
        step("rd_r10");
        chk7("squashed_rd_free", last_obs, 7'b1111000);
        chk32("redir_pcds", pc_ds, 32'd6);

        // Redirect held through a memory wait.
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, LAT_ALU);
        cmd = 2'b01; rdy = 1'b0; redir = 1'b1;
        step("redir_wait1");
        step("redir_wait2");
        chk7("redir_wait_noflush", last_obs, 7'b0001001);
        rdy = 1'b1;
        step("redir_release");
        chk7("redir_release_flush", last_obs, 7'b1111110);
        chk32("redir_wait_pcms", pc_ms, 32'd6);
        cmd = 2'b00; redir = 1'b0;

        // r0 never becomes busy.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd5);
        step("wr_r0");
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd15, LAT_ALU);
        step("rd_r0");
        chk7("r0_nostall", last_obs, 7'b1111000);

        // Reset in the middle of a stall.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 3'd5);
        step("op_r11");
        set_id(1'b1, 5'd11, 1'b1, 5'd11, 1'b1, 5'd16, LAT_ALU);
        step("dep_r11");
        chk7("r11_stall", last_obs, 7'b0111010);
        #2 rst = 1'b1;
        #1;
        chk32("midrst_pcds", pc_ds, 32'd0);
        chk32("midrst_pcms", pc_ms, 32'd0);
        model_clear();
        rst = 1'b0;
        step("after_rst");
        chk7("after_rst_nostall", last_obs, 7'b1111000);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            set_id(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            cmd   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rdy   = 1'($urandom_range(0, 1));
            redir = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised successor to the fixed load-use stall unit of the 5-stage core. It generates per-register pipeline enables and bubble-flushes for IF/ID, ID/EX, EX/MEM and MEM/WB. A per-register countdown scoreboard replaces the single ID_EX_rd compare, so variable-latency producers (loads, multi-cycle ALU ops) are supported. It also adds data-memory wait states, branch-redirect flushing and stall performance counters. It sits beside the pipeline registers in processor and drives all of their enables.

Parameters:
NREG, 32, architectural registers; index 0 is hardwired zero
RIDX_W, $clog2(NREG), register index width
LAT_W, 3, width of latency field and scoreboard counters
MAX_LAT, 7, saturation value for issued latency (must be < 2**LAT_W)
PCNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ID_rs1  in  RIDX_W  source 1 of instruction in ID
ID_rs2  in  RIDX_W  source 2 of instruction in ID
ID_rs1_used  in  1  ID instruction reads rs1
ID_rs2_used  in  1  ID instruction reads rs2
ID_rd  in  RIDX_W  destination of ID instruction
ID_vld  in  1  ID holds a valid instruction
ID_lat  in  LAT_W  extra cycles after EX before result is forwardable (0 = ALU, 1 = load, >1 = multi-cycle)
EX_MEM_mem_cmd  in  2  bus command in MEM stage (BUS_NONE = idle)
DM_rdy  in  1  data memory completes current access this cycle
EX_redirect  in  1  valid taken branch/jump resolved in EX
ST_if_id_en  out  1  IF/ID load enable
ST_id_ex_en  out  1  ID/EX load enable
ST_ex_mem_en  out  1  EX/MEM load enable
ST_mem_wb_en  out  1  MEM/WB load enable
FL_if_id  out  1  load NOOP / vld=0 into IF/ID
FL_id_ex  out  1  load bubble into ID/EX
FL_mem_wb  out  1  load bubble into MEM/WB
PC_data_stalls  out  PCNT_W  count of data-hazard stall cycles
PC_mem_stalls  out  PCNT_W  count of memory-wait cycles

Behaviour:
- State: sb_cnt[NREG] (LAT_W each), two perf counters. Reset (async, rst=1): all sb_cnt=0, both counters=0. Enable/flush outputs are combinational from state and inputs. During rst they are don't-care; the pipeline registers are in reset.
- mem_wait = (EX_MEM_mem_cmd != BUS_NONE) && !DM_rdy.
- hazard = ID_vld && ((ID_rs1_used && ID_rs1!=0 && sb_cnt[ID_rs1]!=0) || (same for rs2)).
- Priority 1, mem_wait: if_id_en = id_ex_en = ex_mem_en = 0, mem_wb_en = 1, FL_mem_wb = 1. No other flush. Scoreboard frozen. A held EX_redirect is acted on when the wait ends.
- Priority 2, EX_redirect (no mem_wait): all enables 1, FL_if_id = 1, FL_id_ex = 1. ID instruction is squashed and not recorded in the scoreboard. A coincident hazard is ignored.
- Priority 3, hazard: if_id_en = 0, id_ex_en = 1 with FL_id_ex = 1, ex_mem_en = mem_wb_en = 1.
- Otherwise all enables 1 and all flushes 0.
- Scoreboard update, only when !mem_wait. First every nonzero sb_cnt decrements by 1. Then, if the ID instruction issues (ID_vld && !hazard && !EX_redirect && ID_rd!=0), sb_cnt[ID_rd] = min(ID_lat, MAX_LAT). The issue write overrides the decrement of the same entry.
- sb_cnt[0] is never written and reads as 0.
- Load-use equivalence: ID_lat=1 yields exactly one bubble for a dependent instruction immediately following; ID_lat=0 yields none.
- PC_data_stalls increments on cycles with hazard && !mem_wait && !EX_redirect. PC_mem_stalls increments on mem_wait cycles. Both wrap modulo 2**PCNT_W.

Decomposition:
- hazard_pkg: LAT_ALU=0, LAT_LOAD=1 constants, latency typedef, stall-cause enum (NONE, MEM_WAIT, REDIRECT, DATA) used for the priority mux.
- BUS_NONE stays in sys_defs.vh.
- One sub-module: hazard_scoreboard, holding the sb_cnt array, decrement/issue logic and the two read ports (busy1, busy2). hazard_ctrl contains the priority mux and the perf counters.

Test Plan:
- Load r5 (ID_lat=1) followed by add r6,r5,r5 -> one cycle with if_id_en=0, FL_id_ex=1. Add issues next cycle. PC_data_stalls=1.
- Op with ID_lat=3 to r7, then dependent read of r7 -> three consecutive stall cycles. sb_cnt[7] reads 3,2,1,0.
- EX_MEM_mem_cmd=BUS_LOAD with DM_rdy low for 4 cycles -> if_id/id_ex/ex_mem enables 0 and FL_mem_wb=1 for 4 cycles. Scoreboard unchanged. PC_mem_stalls=4.
- EX_redirect together with a hazard in ID -> FL_if_id=FL_id_ex=1, no data stall counted, ID_rd not entered in the scoreboard.
- EX_redirect during mem_wait (2 cycles) -> no flush during the wait. Flush occurs on the first cycle DM_rdy=1.
- Writes to r0 with ID_lat=5, then a read of r0 -> no stall. rst pulsed mid-stall -> all sb_cnt=0 and counters=0 immediately; no stall after release.
